// File: rtl/gb_cpu_bus_ctrl.sv
// CPU-side memory bus controller: one request per M-cycle expanded into a T1..T4 bus sequence.
// Optional GB_CPU_BUS_DMA_LOCK_EN blocks non-HRAM accesses while OAM DMA is active.
package gb_cpu_bus_pkg;
    typedef enum logic [3:0] {
        REG_B     = 4'h0,
        REG_C     = 4'h1,
        REG_D     = 4'h2,
        REG_E     = 4'h3,
        REG_H     = 4'h4,
        REG_L     = 4'h5,
        REG_A     = 4'h6,
        REG_F     = 4'h7,
        REG_IR    = 4'h8,
        REG_TMP_L = 4'h9,
        REG_TMP_H = 4'hA
    } regfile_r8_t;
endpackage

module gb_cpu_bus_ctrl
    import gb_cpu_bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC  = 15,
    parameter logic [7:0]  OPEN_BUS_VAL = 8'hFF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    input  regfile_r8_t req_dst,
    output logic        done,
    output logic        timeout,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [7:0]  mem_dout,
    input  logic [7:0]  mem_din,
    input  logic        mem_wait,
    output regfile_r8_t data_bus_req,
    output logic [7:0]  data_bus_data,
    output logic        data_bus_wren,
    input  logic        dma_active
);

    localparam int               CNT_W      = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(TIMEOUT_CYC);
    localparam bit               TIMEOUT_EN = (TIMEOUT_CYC != 0);

    // state | meaning: IDLE no access | T1 address out | T2 strobe on | T3 strobe held, wait | T4 done, data to regfile
    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_T3, S_T4} state_t;

    state_t            state, state_nxt;
    logic              lat_write, lat_write_nxt;
    logic [7:0]        lat_wdata, lat_wdata_nxt;
    regfile_r8_t       lat_dst, lat_dst_nxt;
    logic              lat_block, lat_block_nxt;
    logic [CNT_W-1:0]  wait_cnt, wait_cnt_nxt;
    logic [15:0]       mem_addr_nxt;
    logic              mem_rd_nxt, mem_wr_nxt;
    logic [7:0]        mem_dout_nxt;
    regfile_r8_t       data_bus_req_nxt;
    logic [7:0]        data_bus_data_nxt;
    logic              data_bus_wren_nxt, done_nxt, timeout_nxt;
    logic              t3_exit;
    logic [7:0]        t3_data;
    logic              req_block;

`ifdef GB_CPU_BUS_DMA_LOCK_EN
    assign req_block = dma_active && !((req_addr >= 16'hFF80) && (req_addr <= 16'hFFFE));
`else
    logic dma_unused;
    assign dma_unused = dma_active;
    assign req_block  = 1'b0;
`endif

    assign req_ready = (state == S_IDLE) || (state == S_T4);

    always_comb begin
        state_nxt         = state;
        lat_write_nxt     = lat_write;
        lat_wdata_nxt     = lat_wdata;
        lat_dst_nxt       = lat_dst;
        lat_block_nxt     = lat_block;
        wait_cnt_nxt      = wait_cnt;
        mem_addr_nxt      = mem_addr;
        mem_rd_nxt        = mem_rd;
        mem_wr_nxt        = mem_wr;
        mem_dout_nxt      = mem_dout;
        data_bus_req_nxt  = data_bus_req;
        data_bus_data_nxt = data_bus_data;
        data_bus_wren_nxt = 1'b0;
        done_nxt          = 1'b0;
        timeout_nxt       = 1'b0;
        t3_exit           = 1'b0;
        t3_data           = OPEN_BUS_VAL;

        case (state)
            S_IDLE, S_T4: begin
                mem_rd_nxt = 1'b0;
                mem_wr_nxt = 1'b0;
                if (req_valid) begin
                    state_nxt     = S_T1;
                    lat_write_nxt = req_write;
                    lat_wdata_nxt = req_wdata;
                    lat_dst_nxt   = req_dst;
                    lat_block_nxt = req_block;
                    mem_addr_nxt  = req_addr;
                    wait_cnt_nxt  = '0;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_T1: begin
                state_nxt = S_T2;
                if (!lat_block) begin
                    mem_rd_nxt = !lat_write;
                    mem_wr_nxt = lat_write;
                    if (lat_write) begin
                        mem_dout_nxt = lat_wdata;
                    end
                end
            end
            S_T2: begin
                state_nxt = S_T3;
            end
            S_T3: begin
                // A blocked access never waits on the bus, so its timing stays at 4 cycles.
                if (lat_block) begin
                    t3_exit = 1'b1;
                end else if (!mem_wait) begin
                    t3_exit = 1'b1;
                    t3_data = mem_din;
                end else if (TIMEOUT_EN && (wait_cnt == CNT_MAX)) begin
                    t3_exit     = 1'b1;
                    timeout_nxt = 1'b1;
                end else begin
                    wait_cnt_nxt = wait_cnt + CNT_W'(1);
                end
                if (t3_exit) begin
                    state_nxt  = S_T4;
                    mem_rd_nxt = 1'b0;
                    mem_wr_nxt = 1'b0;
                    done_nxt   = 1'b1;
                    if (!lat_write) begin
                        data_bus_wren_nxt = 1'b1;
                        data_bus_req_nxt  = lat_dst;
                        data_bus_data_nxt = t3_data;
                    end
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            lat_write     <= 1'b0;
            lat_wdata     <= 8'h00;
            lat_dst       <= REG_B;
            lat_block     <= 1'b0;
            wait_cnt      <= '0;
            mem_addr      <= 16'h0000;
            mem_rd        <= 1'b0;
            mem_wr        <= 1'b0;
            mem_dout      <= 8'h00;
            data_bus_req  <= REG_B;
            data_bus_data <= 8'h00;
            data_bus_wren <= 1'b0;
            done          <= 1'b0;
            timeout       <= 1'b0;
        end else begin
            state         <= state_nxt;
            lat_write     <= lat_write_nxt;
            lat_wdata     <= lat_wdata_nxt;
            lat_dst       <= lat_dst_nxt;
            lat_block     <= lat_block_nxt;
            wait_cnt      <= wait_cnt_nxt;
            mem_addr      <= mem_addr_nxt;
            mem_rd        <= mem_rd_nxt;
            mem_wr        <= mem_wr_nxt;
            mem_dout      <= mem_dout_nxt;
            data_bus_req  <= data_bus_req_nxt;
            data_bus_data <= data_bus_data_nxt;
            data_bus_wren <= data_bus_wren_nxt;
            done          <= done_nxt;
            timeout       <= timeout_nxt;
        end
    end

endmodule

// File: tb/tb_gb_cpu_bus_ctrl.sv
// Bench for gb_cpu_bus_ctrl: directed scenarios plus randomized accesses against a transaction-level model.
module tb_gb_cpu_bus_ctrl;
    import gb_cpu_bus_pkg::*;

    localparam int unsigned TB_TIMEOUT = 4;
    localparam logic [7:0]  OPEN_VAL   = 8'hFF;
`ifdef GB_CPU_BUS_DMA_LOCK_EN
    localparam bit DMA_EN = 1'b1;
`else
    localparam bit DMA_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid, req_ready, req_write;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    regfile_r8_t req_dst;
    logic        done, timeout;
    logic [15:0] mem_addr;
    logic        mem_rd, mem_wr;
    logic [7:0]  mem_dout, mem_din;
    logic        mem_wait;
    regfile_r8_t data_bus_req;
    logic [7:0]  data_bus_data;
    logic        data_bus_wren;
    logic        dma_active;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] last_addr;

    gb_cpu_bus_ctrl #(.TIMEOUT_CYC(TB_TIMEOUT), .OPEN_BUS_VAL(OPEN_VAL)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_dst(req_dst),
        .done(done), .timeout(timeout),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_dout(mem_dout), .mem_din(mem_din), .mem_wait(mem_wait),
        .data_bus_req(data_bus_req), .data_bus_data(data_bus_data),
        .data_bus_wren(data_bus_wren), .dma_active(dma_active)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset_vals(input string pfx);
        chk({pfx, "_addr"},    32'(mem_addr), 32'h0);
        chk({pfx, "_rd"},      32'(mem_rd), 32'h0);
        chk({pfx, "_wr"},      32'(mem_wr), 32'h0);
        chk({pfx, "_dout"},    32'(mem_dout), 32'h0);
        chk({pfx, "_data"},    32'(data_bus_data), 32'h0);
        chk({pfx, "_wren"},    32'(data_bus_wren), 32'h0);
        chk({pfx, "_req"},     32'(data_bus_req), 32'h0);
        chk({pfx, "_done"},    32'(done), 32'h0);
        chk({pfx, "_timeout"}, 32'(timeout), 32'h0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_ready", 32'(req_ready), 32'h1);
            chk("idle_done",  32'(done), 32'h0);
            chk("idle_wren",  32'(data_bus_wren), 32'h0);
            chk("idle_rd",    32'(mem_rd), 32'h0);
            chk("idle_wr",    32'(mem_wr), 32'h0);
            chk("idle_addr",  32'(mem_addr), 32'(last_addr));
        end
    endtask

    // Called at a negedge where the controller is ready; returns at the negedge inside T4.
    task automatic run_access(input bit wr, input logic [15:0] addr, input logic [7:0] wd,
                              input regfile_r8_t dst, input int nwait, input logic [7:0] din_ok,
                              input bit dma);
        bit         blk, ex, to, exp_rd, exp_wr;
        int         k;
        logic [7:0] din, exp_d;
        blk    = DMA_EN && dma && !((addr >= 16'hFF80) && (addr <= 16'hFFFE));
        exp_rd = !wr && !blk;
        exp_wr = wr && !blk;
        chk("acc_ready", 32'(req_ready), 32'h1);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wd;
        req_dst = dst; dma_active = dma; mem_wait = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("t1_addr",  32'(mem_addr), 32'(addr));
        chk("t1_rd",    32'(mem_rd), 32'h0);
        chk("t1_wr",    32'(mem_wr), 32'h0);
        chk("t1_ready", 32'(req_ready), 32'h0);
        chk("t1_done",  32'(done), 32'h0);
        req_valid = 1'b0; req_addr = 16'($urandom); req_wdata = 8'($urandom);
        req_write = 1'($urandom); req_dst = REG_B; dma_active = 1'($urandom);
        @(negedge clk);
        chk("t2_rd",   32'(mem_rd), 32'(exp_rd));
        chk("t2_wr",   32'(mem_wr), 32'(exp_wr));
        chk("t2_addr", 32'(mem_addr), 32'(addr));
        if (exp_wr) chk("t2_dout", 32'(mem_dout), 32'(wd));
        k = 0; ex = 0; to = 0; exp_d = OPEN_VAL;
        while (!ex) begin
            @(negedge clk);
            chk("t3_rd",    32'(mem_rd), 32'(exp_rd));
            chk("t3_wr",    32'(mem_wr), 32'(exp_wr));
            chk("t3_done",  32'(done), 32'h0);
            chk("t3_ready", 32'(req_ready), 32'h0);
            if (exp_wr) chk("t3_dout", 32'(mem_dout), 32'(wd));
            mem_wait = (k < nwait);
            din      = (k == nwait) ? din_ok : 8'($urandom);
            mem_din  = din;
            if (blk) begin
                ex = 1; exp_d = OPEN_VAL;
            end else if (!mem_wait) begin
                ex = 1; exp_d = din;
            end else if (TB_TIMEOUT != 0 && k == int'(TB_TIMEOUT)) begin
                ex = 1; to = 1; exp_d = OPEN_VAL;
            end else if (k > 64) begin
                ex = 1;
                chk("t3_bound", 32'(k), 32'h0);
            end else begin
                k++;
            end
        end
        @(negedge clk);
        mem_wait = 1'b0;
        chk("t4_done",    32'(done), 32'h1);
        chk("t4_timeout", 32'(timeout), 32'(to));
        chk("t4_rd",      32'(mem_rd), 32'h0);
        chk("t4_wr",      32'(mem_wr), 32'h0);
        chk("t4_ready",   32'(req_ready), 32'h1);
        chk("t4_wren",    32'(data_bus_wren), 32'(!wr));
        if (!wr) begin
            chk("t4_data", 32'(data_bus_data), 32'(exp_d));
            chk("t4_req",  32'(data_bus_req), 32'(dst));
        end
        last_addr = addr;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not end, got time %0t expected under 500000", $time);
        $fatal(1);
    end

    initial begin
        regfile_r8_t d;
        int          nw;
        logic [15:0] a;
        reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = 16'h0;
        req_wdata = 8'h0; req_dst = REG_B; mem_din = 8'h0; mem_wait = 1'b0;
        dma_active = 1'b0; last_addr = 16'h0;
        repeat (2) @(negedge clk);
        chk_reset_vals("rst0");
        reset_n = 1'b1;
        idle(2);

        // Back-to-back reads, then write, wait stretch and timeout
        run_access(1'b0, 16'h0150, 8'h00, REG_IR,    0, 8'h3E, 1'b0);
        run_access(1'b0, 16'h0151, 8'h00, REG_TMP_L, 0, 8'h12, 1'b0);
        idle(1);
        run_access(1'b1, 16'hC000, 8'hA5, REG_B,     0, 8'h00, 1'b0);
        idle(1);
        run_access(1'b0, 16'hFF44, 8'h00, REG_TMP_L, 3, 8'h90, 1'b0);
        run_access(1'b0, 16'h4000, 8'h00, REG_TMP_H, 20, 8'h55, 1'b0);
        idle(2);

        // Reset pulled during T2 of a read
        req_valid = 1'b1; req_write = 1'b0; req_addr = 16'h1234; req_dst = REG_IR; dma_active = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_pre_rd", 32'(mem_rd), 32'h1);
        reset_n = 1'b0;
        #1;
        chk_reset_vals("rst_mid");
        @(negedge clk);
        reset_n = 1'b1;
        last_addr = 16'h0;
        idle(4);
        run_access(1'b0, 16'h2345, 8'h00, REG_IR, 0, 8'hC3, 1'b0);
        idle(1);

        // DMA lock scenario (blocking only expected when the feature is built in)
        run_access(1'b0, 16'h8000, 8'h00, REG_IR,    0, 8'h11, 1'b1);
        run_access(1'b0, 16'hFF80, 8'h00, REG_TMP_L, 0, 8'h77, 1'b1);
        run_access(1'b1, 16'hD000, 8'h3C, REG_B,     0, 8'h00, 1'b1);
        idle(1);

        for (int i = 0; i < 60; i++) begin
            case ($urandom_range(0, 2))
                0:       d = REG_IR;
                1:       d = REG_TMP_L;
                default: d = REG_TMP_H;
            endcase
            nw = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 7)) : 0;
            a  = ($urandom_range(0, 3) == 0) ? 16'(16'hFF70 + $urandom_range(0, 16'h8F)) : 16'($urandom);
            run_access(1'($urandom), a, 8'($urandom), d, nw, 8'($urandom), 1'($urandom));
            if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/gb_cpu_bus_ctrl.md
Name: gb_cpu_bus_ctrl

Overview:
- CPU-side memory bus controller. It turns one-access-per-M-cycle requests from the CPU control unit into a 4-phase external bus sequence (T1–T4).
- It returns read data to the register file through the regfile's data-bus write port (data_bus_req / data_bus_data / data_bus_wren).
- This block is the initiator end of the data-bus path the regfile consumes: it drives address/strobes outward and delivers IR/TMP loads inward.

Parameters:
- TIMEOUT_CYC, 15: max extra T3 wait cycles before abort; 0 disables the timeout (wait forever).
- OPEN_BUS_VAL, 8'hFF: data returned on timeout or DMA-blocked reads.

Ports:
- clk  input  1  machine clock
- reset_n  input  1  asynchronous active-low reset
- req_valid  input  1  access request
- req_ready  output  1  controller can accept a request this cycle
- req_write  input  1  1 = write, 0 = read
- req_addr  input  16  access address
- req_wdata  input  8  write data
- req_dst  input  regfile_r8_t  regfile destination for read data (REG_IR, REG_TMP_L, REG_TMP_H)
- done  output  1  one-cycle pulse in T4 of every completed access
- timeout  output  1  one-cycle pulse in T4 of a timed-out access
- mem_addr  output  16  external address bus
- mem_rd  output  1  read strobe
- mem_wr  output  1  write strobe
- mem_dout  output  8  write data bus
- mem_din  input  8  read data bus
- mem_wait  input  1  memory not ready; stretches T3
- data_bus_req  output  regfile_r8_t  regfile destination
- data_bus_data  output  8  read data to regfile
- data_bus_wren  output  1  regfile write enable
- dma_active  input  1  OAM DMA in progress; used only with the optional feature

Behaviour:
- Reset (async, reset_n=0):
  - FSM goes to IDLE.
  - mem_addr=16'h0000, mem_rd=0, mem_wr=0, mem_dout=8'h00.
  - data_bus_data=8'h00, data_bus_wren=0, data_bus_req=all-zeros encoding.
  - done=0, timeout=0, wait counter=0.
  - req_ready=1 once reset releases.
- Reset asserted mid-access: strobes drop immediately, the access is discarded, and no done or wren is produced.
- All outputs are registered except req_ready, which is combinational: 1 in IDLE and in T4, else 0.
- Accept when req_valid && req_ready at a clk rising edge. The edge latches write/addr/wdata/dst and the FSM enters T1.
- States, one cycle each unless stretched:
  - IDLE: strobes low; mem_addr holds the last address.
  - T1: mem_addr = latched address; strobes low.
  - T2: read asserts mem_rd. Write asserts mem_wr and drives mem_dout=wdata.
  - T3: strobe held.
    - If mem_wait=1, stay in T3 and increment the wait counter.
    - If mem_wait=0, leave T3. A read captures mem_din on that edge.
    - If TIMEOUT_CYC≠0 and the counter reaches TIMEOUT_CYC while mem_wait=1, leave T3 anyway. The captured data is OPEN_BUS_VAL and timeout is flagged.
  - T4: strobes low; done=1.
    - Read: data_bus_wren=1, data_bus_req=latched dst, data_bus_data=captured byte.
    - Write: data_bus_wren=0.
    - Next state is T1 if a new request is accepted this cycle, else IDLE.
- Latency: the accept edge is followed by T1, T2, T3, T4, so wren/done are high in the 4th cycle after accept.
- Back-to-back throughput is 4 cycles per access when unstretched.
- The wait counter clears on entry to T1. Its width is enough to hold TIMEOUT_CYC.
- req_dst is forwarded unchanged. The regfile ignores destinations other than IR/TMP, so no checking is done here.
- mem_rd and mem_wr are never high simultaneously.
- A request presented while not ready is not lost. The requester holds req_valid until ready is seen.

Optional Feature:
- Macro: GB_CPU_BUS_DMA_LOCK_EN.
- Defined: while dma_active=1 at accept, accesses with address outside FF80–FFFE are blocked.
  - Blocked reads: mem_rd stays low for the whole access; data OPEN_BUS_VAL is delivered in T4.
  - Blocked writes: mem_wr stays low.
  - Timing is unchanged (4 cycles), and done still pulses.
  - HRAM accesses proceed normally.
- Undefined: dma_active is ignored; all accesses go to the bus.

Test Plan:
1. Two back-to-back reads:
   - Stimulus: 0x0150 → REG_IR with mem_din=0x3E, then 0x0151 → REG_TMP_L with mem_din=0x12, req_valid held, mem_wait=0.
   - Response: mem_rd high in T2–T3 of each access. wren pulses 4 and 8 cycles after the first accept, carrying (REG_IR, 0x3E) then (REG_TMP_L, 0x12). The second T1 immediately follows the first T4.
2. Write:
   - Stimulus: 0xC000 ← 0xA5.
   - Response: mem_addr=0xC000 from T1; mem_wr=1 with mem_dout=0xA5 in T2–T3; done pulses in T4; data_bus_wren stays 0.
3. Wait stretch:
   - Stimulus: read 0xFF44 with mem_wait=1 for 3 cycles in T3, then mem_din=0x90.
   - Response: T3 lasts 4 cycles; wren occurs 7 cycles after accept carrying 0x90; timeout=0.
4. Timeout:
   - Stimulus: TIMEOUT_CYC=4, mem_wait stuck at 1, read to REG_TMP_H.
   - Response: T3 exits after 4 wait cycles; T4 has timeout=1, done=1, data 0xFF; FSM then returns to IDLE with req_ready=1.
5. Reset mid-access:
   - Stimulus: reset_n pulled low during T2 of a read.
   - Response: mem_rd=0 asynchronously; no wren or done; all outputs at reset values; a new read after release completes normally.
6. With GB_CPU_BUS_DMA_LOCK_EN and dma_active=1:
   - Stimulus: read 0x8000, then read 0xFF80 with mem_din=0x77.
   - Response: first read has mem_rd never high and delivers 0xFF; second read has mem_rd high and delivers 0x77.
